// File: rtl/nios2sys_onchip_mem_burst_if.sv
// Avalon-MM slave bus for the burst-capable on-chip RAM: command, write data,
// pipelined read return and back-pressure.
interface nios2sys_onchip_mem_burst_if #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 16,
    parameter int BURST_W = 4
);
    logic                  chipselect;
    logic                  read;
    logic                  write;
    logic [ADDR_W-1:0]     address;
    logic [DATA_W/8-1:0]   byteenable;
    logic [BURST_W-1:0]    burstcount;
    logic [DATA_W-1:0]     writedata;
    logic [DATA_W-1:0]     readdata;
    logic                  readdatavalid;
    logic                  waitrequest;

    modport master (
        output chipselect, read, write, address, byteenable, burstcount, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  chipselect, read, write, address, byteenable, burstcount, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/nios2sys_onchip_mem_burst.sv
// On-chip RAM Avalon-MM slave: pipelined burst reads, byte-lane writes, freeze
// write-protect, global stall and optional zero-fill after reset.
module nios2sys_onchip_mem_burst #(
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 38400,
    parameter int ADDR_W         = 16,
    parameter int BURST_W        = 4,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic reset_req,
    input  logic clken,
    input  logic freeze,
    nios2sys_onchip_mem_burst_if.slave bus
);
    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_RBURST} state_e;

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    clr_q, clr_d;
    logic [ADDR_W-1:0]    baddr_q, baddr_d;
    logic [BURST_W-1:0]   rem_q, rem_d;
    logic [BURST_W-1:0]   len;
    logic                 stall, waitreq, accept, issue, mem_we;
    logic [ADDR_W-1:0]    rd_addr, w_addr;
    logic [DATA_W-1:0]    w_data;
    logic [BE_W-1:0]      w_be;

    logic [DATA_W-1:0]    mem [DEPTH];
    logic [DATA_W-1:0]    ram_q_p0;
    logic                 vld_p0_q, vld_p1_q, vld_p2_q;
    logic [DATA_W-1:0]    rdata_p1_q, rdata_p2_q;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < DEPTH_X;
    endfunction

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return (a >= LAST_A) ? '0 : a + ADDR_W'(1);
    endfunction

    assign stall = ~clken | reset_req;
    assign len   = (bus.burstcount == '0) ? BURST_W'(1) : bus.burstcount;

    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        baddr_d = baddr_q;
        rem_d   = rem_q;
        waitreq = 1'b1;
        accept  = 1'b0;
        issue   = 1'b0;
        rd_addr = baddr_q;
        mem_we  = 1'b0;
        w_addr  = bus.address;
        w_data  = bus.writedata;
        w_be    = bus.byteenable;
        unique case (state_q)
            S_CLEAR: begin
                mem_we = 1'b1;
                w_addr = clr_q;
                w_data = '0;
                w_be   = '1;
                clr_d  = clr_q + ADDR_W'(1);
                if (clr_q == LAST_A) begin
                    state_d = S_IDLE;
                    clr_d   = '0;
                end
            end
            S_IDLE: begin
                waitreq = stall | ~reset_n;
                accept  = bus.chipselect & (bus.read | bus.write) & ~waitreq;
                // A simultaneous read and write is treated as a write only.
                if (accept && bus.write) begin
                    mem_we = ~freeze & in_range(bus.address);
                end else if (accept) begin
                    issue   = 1'b1;
                    rd_addr = bus.address;
                    if (len > BURST_W'(1)) begin
                        state_d = S_RBURST;
                        baddr_d = next_addr(bus.address);
                        rem_d   = len - BURST_W'(1);
                    end
                end
            end
            S_RBURST: begin
                issue   = 1'b1;
                baddr_d = next_addr(baddr_q);
                rem_d   = rem_q - BURST_W'(1);
                if (rem_q == BURST_W'(1)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        mem_we = mem_we & ~stall & reset_n;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
            clr_q      <= '0;
            baddr_q    <= '0;
            rem_q      <= '0;
            vld_p0_q   <= 1'b0;
            vld_p1_q   <= 1'b0;
            vld_p2_q   <= 1'b0;
            rdata_p1_q <= '0;
            rdata_p2_q <= '0;
        end else if (!stall) begin
            state_q  <= state_d;
            clr_q    <= clr_d;
            baddr_q  <= baddr_d;
            rem_q    <= rem_d;
            vld_p0_q <= issue;
            // stage 1: RAM output into the readdata register, loaded only by valid beats
            vld_p1_q <= vld_p0_q;
            if (vld_p0_q) rdata_p1_q <= ram_q_p0;
            // stage 2: optional extra output register
            vld_p2_q <= vld_p1_q;
            if (vld_p1_q) rdata_p2_q <= rdata_p1_q;
        end
    end

    // stage 0: RAM array, one write port and one registered read port
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (w_be[b]) mem[w_addr[IDX_W-1:0]][8*b +: 8] <= w_data[8*b +: 8];
            end
        end
        if (issue && !stall) begin
            ram_q_p0 <= in_range(rd_addr) ? mem[rd_addr[IDX_W-1:0]] : '0;
        end
    end

    assign bus.waitrequest   = waitreq;
    assign bus.readdata      = (READ_LATENCY == 2) ? rdata_p2_q : rdata_p1_q;
    assign bus.readdatavalid = ((READ_LATENCY == 2) ? vld_p2_q : vld_p1_q) & ~stall;
endmodule
